// File: rtl/quant2_agc.sv
// 2-bit adaptive quantizer: DC-offset removal with saturation, threshold compare,
// and an integrate-and-dump loop that steers the threshold. Optional: QUANT2_THR_OVERRIDE_EN.
module quant2_agc #(
  parameter int PERIOD_LOG2 = 19,
  parameter int TARGET      = 84,
  parameter int DEADBAND    = 4,
  parameter int T_INIT      = 16,
  parameter int T_MIN       = 1,
  parameter int T_MAX       = 127,
  parameter int STEP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x,
  input  logic [7:0] dc_off,
  input  logic       en,
`ifdef QUANT2_THR_OVERRIDE_EN
  input  logic       thr_ovr_sel,
  input  logic [6:0] thr_ovr,
`endif
  output logic [1:0] q,
  output logic [6:0] thr,
  output logic [7:0] frac,
  output logic       dump,
  output logic       lock
);

  localparam int N    = PERIOD_LOG2;
  localparam int LO_I = (TARGET > DEADBAND) ? (TARGET - DEADBAND) : 0;

  localparam logic [8:0] HI9    = 9'(TARGET + DEADBAND);
  localparam logic [8:0] LO9    = 9'(LO_I);
  localparam logic [8:0] STEP9  = 9'(STEP);
  localparam logic [8:0] TMAX9  = 9'(T_MAX);
  localparam logic [8:0] TMIN9  = 9'(T_MIN);
  localparam logic [6:0] TINIT7 = 7'(T_INIT);

  logic [7:0]   v_q, v_d;
  logic [1:0]   q_q, q_d;
  logic [6:0]   thr_q, thr_d;
  logic [7:0]   frac_q, frac_d;
  logic         dump_q, dump_d;
  logic         lock_q, lock_d;
  logic [1:0]   run_q, run_d;
  logic [N-1:0] c_q, c_d;
  logic [N-1:0] o_q, o_d;

  logic [8:0]        d;
  logic [6:0]        t_sel;
  logic signed [8:0] v9, t9;
  logic              terminal, above, below;
  logic [7:0]        frac_new;
  logic [8:0]        thr9;
  logic              ovr_active;

`ifdef QUANT2_THR_OVERRIDE_EN
  assign ovr_active = thr_ovr_sel;
  assign t_sel      = thr_ovr_sel ? thr_ovr : thr_q;
`else
  assign ovr_active = 1'b0;
  assign t_sel      = thr_q;
`endif

  assign terminal = &c_q;
  assign frac_new = o_q[N-1 -: 8];
  assign thr9     = {2'b00, thr_q};
  assign above    = {1'b0, frac_new} > HI9;
  assign below    = {1'b0, frac_new} < LO9;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    d   = {x[7], x} - {dc_off[7], dc_off};
    v_d = d[7:0];
    // Overflow out of 8 bits shows up as the two top bits disagreeing.
    if (d[8] != d[7]) v_d = d[8] ? 8'h80 : 8'h7f;

    v9 = {v_q[7], v_q};
    t9 = {2'b00, t_sel};
    if (v9 >= t9)        q_d = 2'b01;
    else if (v9 >= 9'sd0) q_d = 2'b00;
    else if (v9 >= -t9)  q_d = 2'b11;
    else                 q_d = 2'b10;

    c_d    = c_q + 1'b1;
    o_d    = terminal ? '0 : o_q + N'(q_q[1] ^ q_q[0]);
    frac_d = terminal ? frac_new : frac_q;
    dump_d = terminal;

    thr_d  = thr_q;
    run_d  = run_q;
    lock_d = lock_q;
    if (!en) begin
      run_d  = 2'd0;
      lock_d = 1'b0;
    end else if (terminal) begin
      if (above) begin
        thr_d = (thr9 + STEP9 > TMAX9) ? TMAX9[6:0] : 7'(thr9 + STEP9);
      end else if (below) begin
        thr_d = (thr9 < TMIN9 + STEP9) ? TMIN9[6:0] : 7'(thr9 - STEP9);
      end
      if (above || below) begin
        run_d  = 2'd0;
        lock_d = 1'b0;
      end else begin
        lock_d = (run_q == 2'd3);
        run_d  = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      q_q    <= '0;
      thr_q  <= TINIT7;
      frac_q <= '0;
      dump_q <= 1'b0;
      lock_q <= 1'b0;
      run_q  <= '0;
      c_q    <= '0;
      o_q    <= '0;
    end else begin
      v_q    <= v_d;
      q_q    <= q_d;
      thr_q  <= thr_d;
      frac_q <= frac_d;
      dump_q <= dump_d;
      lock_q <= lock_d;
      run_q  <= run_d;
      c_q    <= c_d;
      o_q    <= o_d;
    end
  end

  assign q    = q_q;
  assign thr  = thr_q;
  assign frac = frac_q;
  assign dump = dump_q;
  assign lock = lock_q & ~ovr_active;

endmodule

// File: tb/tb_quant2_agc.sv
// Directed bench for quant2_agc with a 1024-cycle dump window.
module tb_quant2_agc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] x = 8'd0;
  logic [7:0] dc_off = 8'd0;
  logic       en = 1'b1;
  logic [1:0] q;
  logic [6:0] thr;
  logic [7:0] frac;
  logic       dump;
  logic       lock;

  int errors = 0;
  int checks = 0;
  int ph = 0;
  bit pat = 1'b0;
  int cyc;

  quant2_agc #(.PERIOD_LOG2(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .dc_off(dc_off),
    .en(en),
`ifdef QUANT2_THR_OVERRIDE_EN
    .thr_ovr_sel(1'b0),
    .thr_ovr(7'd0),
`endif
    .q(q),
    .thr(thr),
    .frac(frac),
    .dump(dump),
    .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Steps clocks until dump is seen (bounded), driving the 50,5,5 pattern when enabled.
  task automatic run_to_dump(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (pat) begin
        x = (ph == 0) ? 8'd50 : 8'd5;
        ph = (ph + 1) % 3;
      end
    end while (!dump && n < 1100);
    check("dump_seen", int'(dump), 1);
  endtask

  task automatic apply_q(input string tag, input logic [7:0] xv, input logic [7:0] dv,
                         input int exp);
    x = xv;
    dc_off = dv;
    repeat (2) @(posedge clk);
    #1;
    check(tag, int'(q), exp);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_q", int'(q), 0);
    check("rst_thr", int'(thr), 16);
    check("rst_frac", int'(frac), 0);
    check("rst_dump", int'(dump), 0);
    check("rst_lock", int'(lock), 0);

    // Threshold boundaries at thr=16
    apply_q("q_x16", 8'd16, 8'd0, 1);
    apply_q("q_x15", 8'd15, 8'd0, 0);
    apply_q("q_xm16", 8'hF0, 8'd0, 3);
    apply_q("q_xm17", 8'hEF, 8'd0, 2);

    // Saturation
    apply_q("sat_neg", 8'h80, 8'd100, 2);
    apply_q("sat_pos", 8'd127, 8'h9C, 1);
    apply_q("sat_zero", 8'd0, 8'd0, 0);

    // Loop up: constant x=50 raises thr by one per dump until 51
    x = 8'd50;
    dc_off = 8'd0;
    do_reset();
    run_to_dump(cyc);
    check("up_frac1", int'(frac), 255);
    check("up_dump1", int'(dump), 1);
    check("up_thr1", int'(thr), 17);
    for (int k = 18; k <= 51; k++) begin
      run_to_dump(cyc);
      check("up_thr", int'(thr), k);
      check("up_frac", int'(frac), 255);
    end

    // Deadband and lock with a 1/3 outer pattern
    pat = 1'b1;
    ph = 1;
    x = 8'd50;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      run_to_dump(cyc);
      check("db_frac", int'(frac), 85);
      check("db_thr", int'(thr), 16);
      check("db_lock", int'(lock), (k >= 4) ? 1 : 0);
    end
    pat = 1'b0;
    x = 8'd5;
    run_to_dump(cyc);
    check("unlock_frac", int'(frac), 0);
    check("unlock_lock", int'(lock), 0);
    check("unlock_thr", int'(thr), 15);

    // Clamp at T_MIN, then freeze with en=0
    x = 8'd0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      run_to_dump(cyc);
      check("clamp_thr", int'(thr), (16 - k < 1) ? 1 : 16 - k);
    end
    en = 1'b0;
    x = 8'd50;
    run_to_dump(cyc);
    check("frz_frac", int'(frac), 255);
    check("frz_thr", int'(thr), 1);
    check("frz_lock", int'(lock), 0);

    // Reset mid-window at c=300
    en = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_q", int'(q), 0);
    check("mid_thr", int'(thr), 16);
    check("mid_frac", int'(frac), 0);
    check("mid_dump", int'(dump), 0);
    check("mid_lock", int'(lock), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_to_dump(cyc);
    check("mid_window", cyc, 1024);
    check("mid_frac2", int'(frac), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quant2_agc.md
Name: quant2_agc

Overview:
- Upstream of the 2-bit sign/magnitude histogram and the DC integrate-and-dump stage.
- Takes 8-bit signed ADC samples and subtracts a programmable DC offset with saturation.
- Quantizes the result to a 2-bit code against an adaptive magnitude threshold.
- Closed loop: integrate-and-dump of the outer-level count steers the threshold so the outer fraction tracks a target (about 1/3). Its q output drives the histogram's x input.

Parameters:
- PERIOD_LOG2, 19: dump window length is 2^PERIOD_LOG2 cycles.
- TARGET, 84: desired outer fraction, in units of 1/256.
- DEADBAND, 4: no threshold change while |frac - TARGET| <= DEADBAND.
- T_INIT, 16: threshold value at reset.
- T_MIN, 1: lower clamp on the threshold.
- T_MAX, 127: upper clamp on the threshold.
- STEP, 1: threshold increment or decrement per dump.

Ports:
- clk, input, 1: sample clock; all logic on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- x, input, 8: signed two's-complement sample, one per clock.
- dc_off, input, 8: signed offset in LSB, subtracted from x; quasi-static.
- en, input, 1: 1 = threshold adaptation enabled; 0 = threshold frozen.
- q, output, 2: quantized code (see Behaviour).
- thr, output, 7: current unsigned threshold.
- frac, output, 8: last dumped outer fraction, in 1/256 units.
- dump, output, 1: one-cycle pulse on the cycle frac/thr update.
- lock, output, 1: 1 after 4 consecutive dumps inside the deadband.

Behaviour:
- Reset values (async, rst_n=0):
  - q=00, thr=T_INIT, frac=0, dump=0, lock=0.
  - Window counter c=0, outer counter o=0, pipeline registers 0, lock run counter 0.
- Stage 1 (registered):
  - Compute 9-bit d = sext(x) - sext(dc_off).
  - Saturate to v in [-128, 127].
- Stage 2 (registered):
  - Compare v against T = {0, thr}, sign-extended to 9 bits.
  - q=01 if v >= T.
  - q=00 if 0 <= v < T.
  - q=11 if -T <= v < 0.
  - q=10 if v < -T.
  - Outer codes (01, 10) are those with q[1]^q[0]=1.
- Latency: x to q is 2 cycles. A thr change takes effect on the stage-2 compare the cycle after the dump.
- Window counter c (PERIOD_LOG2 bits) increments every cycle and wraps at all-ones.
- Outer counter o (PERIOD_LOG2 bits):
  - Non-terminal cycle: o += (q[1]^q[0]), using the registered q currently on the output.
  - Terminal cycle (c all-ones): o <= 0. The q on that cycle is not counted, so at most 2^N-1 counts and no overflow.
- Terminal cycle also does:
  - frac <= o[N-1:N-8], where N = PERIOD_LOG2 and N >= 8.
  - dump=1 for that cycle only.
- Threshold update, on the terminal cycle only, when en=1:
  - frac_new > TARGET+DEADBAND: thr <= min(thr+STEP, T_MAX).
  - frac_new < TARGET-DEADBAND: thr <= max(thr-STEP, T_MIN).
  - Otherwise thr is held.
  - Comparisons use frac_new (the value being dumped), not the old frac. Arithmetic is done 9-bit unsigned so nothing wraps.
- Threshold with en=0: thr is held, but frac and dump still update; lock is forced to 0 and its run counter cleared.
- Lock:
  - 2-bit run counter saturating at 3; increments on each in-deadband dump and clears on an out-of-deadband dump.
  - lock=1 when the run counter is already 3 and the current dump is in-deadband, i.e. from the 4th consecutive in-deadband dump. lock clears on the same dump that breaks the run.
- en toggling mid-window has no effect on the counters; only the update at the next dump is gated.
- rst_n asserted mid-window: everything returns to reset values immediately; the first window after release is a full 2^N cycles.
- dc_off changes take effect on the next stage-1 register; no glitch filtering.

Optional Feature:
- Macro QUANT2_THR_OVERRIDE_EN.
- Defined:
  - Adds input thr_ovr_sel (1 bit) and input thr_ovr (7 bits).
  - When thr_ovr_sel=1, stage 2 compares against thr_ovr instead of thr.
  - The loop keeps measuring and updating thr as normal, and the thr port still reports the loop value.
  - lock is forced to 0 while thr_ovr_sel=1.
- Not defined: both ports are absent and stage 2 always uses thr.

Test Plan:
- Threshold boundaries: thr=16 (reset), dc_off=0. x = 16, 15, -16, -17 gives q = 01, 00, 11, 10, each 2 cycles after x is applied.
- Saturation: x=-128 with dc_off=+100 gives q=10; x=127 with dc_off=-100 gives q=01; x=0 with dc_off=0 gives q=00.
- Loop up (PERIOD_LOG2=10, en=1, x=50 constant): first dump has frac=255 and dump pulses; thr goes 16→17 and keeps rising by 1 per dump until q turns inner (thr reaches 51).
- Deadband and lock (PERIOD_LOG2=10, thr=16, x repeating 50, 5, 5): frac=85 each dump, thr stays 16, lock=1 from the 4th dump, and lock drops when x is switched to constant 5.
- Clamp and freeze: x=0 constant drives thr down to T_MIN=1 and it holds there. Then with en=0 and x=50, frac=255 but thr stays 1 and lock=0.
- Reset mid-window: pull rst_n low at c=300. All outputs return to reset values asynchronously, and the next dump arrives exactly 1024 cycles after release.
